// File: rtl/axi_read_arbiter_if.sv
// AXI read-channel bundle (AR address + R data) between a master and a slave.
// The same bundle is used on both sides of the arbiter, with different ID widths.
interface axi_read_arbiter_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 4,
   parameter int DATA_W = 32
);
   logic [ID_W-1:0]   ar_id;
   logic [ADDR_W-1:0] ar_addr;
   logic [LEN_W-1:0]  ar_len;
   logic [2:0]        ar_size;
   logic [1:0]        ar_burst;
   logic              ar_valid;
   logic              ar_ready;
   logic [ID_W-1:0]   r_id;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_resp;
   logic              r_last;
   logic              r_valid;
   logic              r_ready;

   modport master (
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
      input  ar_ready, r_id, r_data, r_resp, r_last, r_valid
   );

   modport slave (
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
      output ar_ready, r_id, r_data, r_resp, r_last, r_valid
   );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-master, one-slave AXI read arbiter. Round-robin grant of the AR channel,
// one outstanding transaction, R burst routed back combinationally to the
// granted master. The slave-side ID carries a 4-bit master tag above ARID.
module axi_read_arbiter #(
   parameter int ID_BITS   = 4,
   parameter int ADDR_BITS = 32,
   parameter int LEN_BITS  = 4,
   parameter int DATA_BITS = 32
) (
   input logic                clk,
   input logic                rst,
   axi_read_arbiter_if.slave  m0,
   axi_read_arbiter_if.slave  m1,
   axi_read_arbiter_if.master mem
);
   localparam int TAG_BITS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t state, state_next;
   logic   grant, grant_next;
   logic   prio, prio_next;

   // Granted master's request fields and R-channel ready.
   logic [ID_BITS-1:0]   ar_id_sel;
   logic [ADDR_BITS-1:0] ar_addr_sel;
   logic [LEN_BITS-1:0]  ar_len_sel;
   logic [2:0]           ar_size_sel;
   logic [1:0]           ar_burst_sel;
   logic                 ar_valid_sel;
   logic                 r_ready_sel;

   assign ar_id_sel    = grant ? m1.ar_id    : m0.ar_id;
   assign ar_addr_sel  = grant ? m1.ar_addr  : m0.ar_addr;
   assign ar_len_sel   = grant ? m1.ar_len   : m0.ar_len;
   assign ar_size_sel  = grant ? m1.ar_size  : m0.ar_size;
   assign ar_burst_sel = grant ? m1.ar_burst : m0.ar_burst;
   assign ar_valid_sel = grant ? m1.ar_valid : m0.ar_valid;
   assign r_ready_sel  = grant ? m1.r_ready  : m0.r_ready;

   // Output values decoded from the current state, index 0/1 = master 0/1.
   logic [ID_BITS+TAG_BITS-1:0] ar_id_s;
   logic [ADDR_BITS-1:0]        ar_addr_s;
   logic [LEN_BITS-1:0]         ar_len_s;
   logic [2:0]                  ar_size_s;
   logic [1:0]                  ar_burst_s;
   logic                        ar_valid_s;
   logic                        r_ready_s;
   logic [1:0]                  ar_ready_m;
   logic [1:0]                  r_valid_m;
   logic [1:0]                  r_last_m;
   logic [ID_BITS-1:0]          r_id_m   [2];
   logic [DATA_BITS-1:0]        r_data_m [2];
   logic [1:0]                  r_resp_m [2];

   // The tag bits of the returned ID are not needed for routing: with one
   // outstanding transaction the grant register already names the owner.
   logic unused_rid_tag;
   assign unused_rid_tag = ^mem.r_id[ID_BITS+TAG_BITS-1:ID_BITS];

   // State, grant and round-robin pointer; reset aborts any burst in flight.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         grant <= 1'b0;
         prio  <= 1'b0;
      end else begin
         state <= state_next;
         grant <= grant_next;
         prio  <= prio_next;
      end
   end

   // Arbitration, handshake tracking and AR/R routing for the current state.
   // NOTE: every signal written here gets a default first, so no path infers a latch.
   always_comb begin
      state_next  = state;
      grant_next  = grant;
      prio_next   = prio;
      ar_id_s     = '0;
      ar_addr_s   = '0;
      ar_len_s    = '0;
      ar_size_s   = '0;
      ar_burst_s  = '0;
      ar_valid_s  = 1'b0;
      r_ready_s   = 1'b0;
      ar_ready_m  = '0;
      r_valid_m   = '0;
      r_last_m    = '0;
      r_id_m[0]   = '0;
      r_id_m[1]   = '0;
      r_data_m[0] = '0;
      r_data_m[1] = '0;
      r_resp_m[0] = '0;
      r_resp_m[1] = '0;

      case (state)
         IDLE: begin
            if (m0.ar_valid && m1.ar_valid) begin
               grant_next = prio;
               state_next = ADDR;
            end else if (m0.ar_valid) begin
               grant_next = 1'b0;
               state_next = ADDR;
            end else if (m1.ar_valid) begin
               grant_next = 1'b1;
               state_next = ADDR;
            end
         end

         ADDR: begin
            ar_valid_s        = ar_valid_sel;
            ar_id_s           = {{(TAG_BITS-1){1'b0}}, grant, ar_id_sel};
            ar_addr_s         = ar_addr_sel;
            ar_len_s          = ar_len_sel;
            ar_size_s         = ar_size_sel;
            ar_burst_s        = ar_burst_sel;
            ar_ready_m[grant] = mem.ar_ready;
            if (ar_valid_sel && mem.ar_ready) begin
               state_next = DATA;
            end
         end

         DATA: begin
            r_valid_m[grant] = mem.r_valid;
            r_last_m[grant]  = mem.r_last;
            r_id_m[grant]    = mem.r_id[ID_BITS-1:0];
            r_data_m[grant]  = mem.r_data;
            r_resp_m[grant]  = mem.r_resp;
            r_ready_s        = r_ready_sel;
            if (mem.r_valid && r_ready_sel && mem.r_last) begin
               state_next = IDLE;
               prio_next  = ~grant;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign mem.ar_id    = ar_id_s;
   assign mem.ar_addr  = ar_addr_s;
   assign mem.ar_len   = ar_len_s;
   assign mem.ar_size  = ar_size_s;
   assign mem.ar_burst = ar_burst_s;
   assign mem.ar_valid = ar_valid_s;
   assign mem.r_ready  = r_ready_s;

   assign m0.ar_ready  = ar_ready_m[0];
   assign m0.r_valid   = r_valid_m[0];
   assign m0.r_last    = r_last_m[0];
   assign m0.r_id      = r_id_m[0];
   assign m0.r_data    = r_data_m[0];
   assign m0.r_resp    = r_resp_m[0];

   assign m1.ar_ready  = ar_ready_m[1];
   assign m1.r_valid   = r_valid_m[1];
   assign m1.r_last    = r_last_m[1];
   assign m1.r_id      = r_id_m[1];
   assign m1.r_data    = r_data_m[1];
   assign m1.r_resp    = r_resp_m[1];
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Testbench for axi_read_arbiter: directed master/slave stimulus, a
// transaction-level reference model compared on every falling edge, and
// literal expectations for the directed scenarios.
module tb_axi_read_arbiter;
   logic clk;
   logic rst;

   axi_read_arbiter_if #(.ID_W(4), .ADDR_W(32), .LEN_W(4), .DATA_W(32)) m0_if ();
   axi_read_arbiter_if #(.ID_W(4), .ADDR_W(32), .LEN_W(4), .DATA_W(32)) m1_if ();
   axi_read_arbiter_if #(.ID_W(8), .ADDR_W(32), .LEN_W(4), .DATA_W(32)) mem_if ();

   axi_read_arbiter #(.ID_BITS(4), .ADDR_BITS(32), .LEN_BITS(4), .DATA_BITS(32)) dut (
      .clk (clk),
      .rst (rst),
      .m0  (m0_if),
      .m1  (m1_if),
      .mem (mem_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic [3:0]  id;
   } beat_t;

   beat_t      got0[$];
   beat_t      got1[$];
   logic [3:0] ar_log[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expire(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // Transaction-level model: who owns the single outstanding transaction,
   // whether its address has been accepted, and who wins the next tie.
   int own    = -1;
   bit ar_done = 1'b0;
   int favour = 0;

   always @(negedge clk) begin : model_cmp
      logic        av  [2];
      logic [3:0]  aid [2];
      logic [31:0] aad [2];
      logic [3:0]  aln [2];
      logic [2:0]  asz [2];
      logic [1:0]  abt [2];
      logic        rrd [2];
      logic        e_arvalid, e_rready;
      logic [7:0]  e_arid;
      logic [31:0] e_araddr;
      logic [3:0]  e_arlen;
      logic [2:0]  e_arsize;
      logic [1:0]  e_arburst;
      logic        e_arready [2];
      logic        e_rvalid  [2];
      logic        e_rlast   [2];
      logic [3:0]  e_rid     [2];
      logic [31:0] e_rdata   [2];
      logic [1:0]  e_rresp   [2];
      logic        x_arready [2];
      logic        x_rvalid  [2];
      logic        x_rlast   [2];
      logic [3:0]  x_rid     [2];
      logic [31:0] x_rdata   [2];
      logic [1:0]  x_rresp   [2];
      beat_t       b;

      av[0] = m0_if.ar_valid;  av[1] = m1_if.ar_valid;
      aid[0] = m0_if.ar_id;    aid[1] = m1_if.ar_id;
      aad[0] = m0_if.ar_addr;  aad[1] = m1_if.ar_addr;
      aln[0] = m0_if.ar_len;   aln[1] = m1_if.ar_len;
      asz[0] = m0_if.ar_size;  asz[1] = m1_if.ar_size;
      abt[0] = m0_if.ar_burst; abt[1] = m1_if.ar_burst;
      rrd[0] = m0_if.r_ready;  rrd[1] = m1_if.r_ready;
      x_arready[0] = m0_if.ar_ready; x_arready[1] = m1_if.ar_ready;
      x_rvalid[0]  = m0_if.r_valid;  x_rvalid[1]  = m1_if.r_valid;
      x_rlast[0]   = m0_if.r_last;   x_rlast[1]   = m1_if.r_last;
      x_rid[0]     = m0_if.r_id;     x_rid[1]     = m1_if.r_id;
      x_rdata[0]   = m0_if.r_data;   x_rdata[1]   = m1_if.r_data;
      x_rresp[0]   = m0_if.r_resp;   x_rresp[1]   = m1_if.r_resp;

      e_arvalid = 1'b0; e_rready = 1'b0; e_arid = '0; e_araddr = '0;
      e_arlen = '0; e_arsize = '0; e_arburst = '0;
      for (int k = 0; k < 2; k++) begin
         e_arready[k] = 1'b0; e_rvalid[k] = 1'b0; e_rlast[k] = 1'b0;
         e_rid[k] = '0; e_rdata[k] = '0; e_rresp[k] = '0;
      end

      if (rst && own >= 0 && !ar_done) begin
         e_arvalid      = av[own];
         e_arid         = {4'(own), aid[own]};
         e_araddr       = aad[own];
         e_arlen        = aln[own];
         e_arsize       = asz[own];
         e_arburst      = abt[own];
         e_arready[own] = mem_if.ar_ready;
      end else if (rst && own >= 0) begin
         e_rvalid[own] = mem_if.r_valid;
         e_rlast[own]  = mem_if.r_last;
         e_rid[own]    = mem_if.r_id[3:0];
         e_rdata[own]  = mem_if.r_data;
         e_rresp[own]  = mem_if.r_resp;
         e_rready      = rrd[own];
      end

      check("s_arvalid", mem_if.ar_valid, e_arvalid);
      check("s_arid",    mem_if.ar_id,    e_arid);
      check("s_araddr",  mem_if.ar_addr,  e_araddr);
      check("s_arlen",   mem_if.ar_len,   e_arlen);
      check("s_arsize",  mem_if.ar_size,  e_arsize);
      check("s_arburst", mem_if.ar_burst, e_arburst);
      check("s_rready",  mem_if.r_ready,  e_rready);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("m%0d_arready", k), x_arready[k], e_arready[k]);
         check($sformatf("m%0d_rvalid", k),  x_rvalid[k],  e_rvalid[k]);
         check($sformatf("m%0d_rlast", k),   x_rlast[k],   e_rlast[k]);
         check($sformatf("m%0d_rid", k),     x_rid[k],     e_rid[k]);
         check($sformatf("m%0d_rdata", k),   x_rdata[k],   e_rdata[k]);
         check($sformatf("m%0d_rresp", k),   x_rresp[k],   e_rresp[k]);
      end

      if (!rst) begin
         own     = -1;
         ar_done = 1'b0;
         favour  = 0;
      end else begin
         // Beats actually handed to each master, straight from the DUT.
         if (m0_if.r_valid && m0_if.r_ready) begin
            b.data = m0_if.r_data; b.last = m0_if.r_last; b.id = m0_if.r_id;
            got0.push_back(b);
         end
         if (m1_if.r_valid && m1_if.r_ready) begin
            b.data = m1_if.r_data; b.last = m1_if.r_last; b.id = m1_if.r_id;
            got1.push_back(b);
         end
         // Advance the model across the coming rising edge.
         if (own < 0) begin
            ar_done = 1'b0;
            if (av[0] && av[1]) own = favour;
            else if (av[0])     own = 0;
            else if (av[1])     own = 1;
         end else if (!ar_done) begin
            if (av[own] && mem_if.ar_ready) ar_done = 1'b1;
         end else if (mem_if.r_valid && rrd[own] && mem_if.r_last) begin
            favour = (own == 0) ? 1 : 0;
            own    = -1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_if.ar_valid = 0; m0_if.ar_id = 0; m0_if.ar_addr = 0; m0_if.ar_len = 0;
      m0_if.ar_size = 0; m0_if.ar_burst = 0; m0_if.r_ready = 1;
      m1_if.ar_valid = 0; m1_if.ar_id = 0; m1_if.ar_addr = 0; m1_if.ar_len = 0;
      m1_if.ar_size = 0; m1_if.ar_burst = 0; m1_if.r_ready = 1;
      mem_if.ar_ready = 0; mem_if.r_valid = 0; mem_if.r_id = 0;
      mem_if.r_data = 0; mem_if.r_resp = 0; mem_if.r_last = 0;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      clear_inputs();
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic issue(input int k, input logic [3:0] id, input logic [31:0] addr,
                        input logic [3:0] len);
      if (k == 0) begin
         m0_if.ar_id = id; m0_if.ar_addr = addr; m0_if.ar_len = len;
         m0_if.ar_size = 3'd2; m0_if.ar_burst = 2'd1; m0_if.ar_valid = 1'b1;
      end else begin
         m1_if.ar_id = id; m1_if.ar_addr = addr; m1_if.ar_len = len;
         m1_if.ar_size = 3'd2; m1_if.ar_burst = 2'd1; m1_if.ar_valid = 1'b1;
      end
   endtask

   task automatic beat(input logic [7:0] id, input logic [31:0] data, input logic last);
      mem_if.r_valid = 1'b1; mem_if.r_id = id; mem_if.r_data = data;
      mem_if.r_resp = 2'd0; mem_if.r_last = last;
   endtask

   task automatic r_idle();
      mem_if.r_valid = 1'b0; mem_if.r_last = 1'b0; mem_if.r_data = '0; mem_if.r_id = '0;
   endtask

   // Simple memory slave: accept the next AR, then return ARLEN+1 beats of base+i.
   task automatic serve(input logic [31:0] base);
      logic [7:0] id;
      logic [3:0] len;
      bit         from1;
      int         n;
      mem_if.ar_ready = 1'b1;
      #1;
      n = 0;
      while (!mem_if.ar_valid && n < 40) begin tick(); n++; end
      if (!mem_if.ar_valid) begin expire("serve_ar"); mem_if.ar_ready = 1'b0; return; end
      id    = mem_if.ar_id;
      len   = mem_if.ar_len;
      from1 = m1_if.ar_ready;
      tick();
      if (from1) m1_if.ar_valid = 1'b0;
      else       m0_if.ar_valid = 1'b0;
      mem_if.ar_ready = 1'b0;
      ar_log.push_back(id[7:4]);
      for (int i = 0; i <= int'(len); i++) begin
         beat(id, base + 32'(i), i == int'(len));
         #1;
         n = 0;
         while (!mem_if.r_ready && n < 40) begin tick(); n++; end
         if (!mem_if.r_ready) begin expire("serve_r"); r_idle(); return; end
         tick();
      end
      r_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      clear_inputs();
      #2;
      check("rst_s_arvalid", mem_if.ar_valid, 1'b0);
      check("rst_s_rready",  mem_if.r_ready,  1'b0);
      check("rst_m0_arready", m0_if.ar_ready, 1'b0);
      check("rst_m1_rvalid",  m1_if.r_valid,  1'b0);
      apply_reset();

      // 1. M0 alone, single-beat burst.
      issue(0, 4'h5, 32'h0001_0040, 4'd0);
      mem_if.ar_ready = 1'b1;
      #1;
      check("t1_req_cycle_arvalid", mem_if.ar_valid, 1'b0);
      tick();
      check("t1_arvalid", mem_if.ar_valid, 1'b1);
      check("t1_arid",    mem_if.ar_id,    8'h05);
      check("t1_araddr",  mem_if.ar_addr,  32'h0001_0040);
      check("t1_arready0", m0_if.ar_ready, 1'b1);
      check("t1_arready1", m1_if.ar_ready, 1'b0);
      tick();
      m0_if.ar_valid  = 1'b0;
      mem_if.ar_ready = 1'b0;
      got0.delete();
      beat(8'h05, 32'hCAFE_0000, 1'b1);
      #1;
      check("t1_rvalid0", m0_if.r_valid, 1'b1);
      check("t1_rlast0",  m0_if.r_last,  1'b1);
      check("t1_rid0",    m0_if.r_id,    4'h5);
      check("t1_rdata0",  m0_if.r_data,  32'hCAFE_0000);
      check("t1_rvalid1", m1_if.r_valid, 1'b0);
      check("t1_srready", mem_if.r_ready, 1'b1);
      tick();
      r_idle();
      #1;
      check("t1_done_rvalid0", m0_if.r_valid, 1'b0);
      check("t1_beats0", got0.size(), 1);

      // 2. Simultaneous requests, twice: M0 wins both ties.
      apply_reset();
      ar_log.delete();
      issue(0, 4'h1, 32'h0000_1000, 4'd1);
      issue(1, 4'h2, 32'h0000_1100, 4'd1);
      serve(32'hA000_0000);
      serve(32'hA100_0000);
      issue(0, 4'h1, 32'h0000_1200, 4'd0);
      issue(1, 4'h2, 32'h0000_1300, 4'd0);
      serve(32'hA200_0000);
      serve(32'hA300_0000);
      check("t2_grants", ar_log.size(), 4);
      if (ar_log.size() == 4) begin
         check("t2_grant_a", ar_log[0], 4'd0);
         check("t2_grant_b", ar_log[1], 4'd1);
         check("t2_grant_c", ar_log[2], 4'd0);
         check("t2_grant_d", ar_log[3], 4'd1);
      end

      // 3. M1 four-beat burst with a 3-cycle RREADY stall on beat 2.
      got1.delete();
      issue(1, 4'h3, 32'h0000_2000, 4'd3);
      mem_if.ar_ready = 1'b1;
      tick();
      check("t3_arid", mem_if.ar_id, 8'h13);
      tick();
      m1_if.ar_valid  = 1'b0;
      mem_if.ar_ready = 1'b0;
      beat(8'h13, 32'hB000_0000, 1'b0);
      tick();
      beat(8'h13, 32'hB000_0001, 1'b0);
      m1_if.r_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("t3_stall_srready", mem_if.r_ready, 1'b0);
         check("t3_stall_rdata", m1_if.r_data, 32'hB000_0001);
         tick();
      end
      m1_if.r_ready = 1'b1;
      tick();
      beat(8'h13, 32'hB000_0002, 1'b0);
      tick();
      beat(8'h13, 32'hB000_0003, 1'b1);
      #1;
      check("t3_rlast_beat4", m1_if.r_last, 1'b1);
      tick();
      r_idle();
      check("t3_beats", got1.size(), 4);
      for (int i = 0; i < got1.size(); i++) begin
         check($sformatf("t3_data%0d", i), got1[i].data, 32'hB000_0000 + 32'(i));
         check($sformatf("t3_last%0d", i), got1[i].last, i == 3);
      end

      // 4. M0 requests while M1 is mid-burst.
      issue(1, 4'h7, 32'h0000_6000, 4'd1);
      mem_if.ar_ready = 1'b1;
      tick();
      tick();
      m1_if.ar_valid = 1'b0;
      issue(0, 4'h2, 32'h0000_7000, 4'd0);
      beat(8'h17, 32'hD000_0000, 1'b0);
      #1;
      check("t4_pending_a", m0_if.ar_ready, 1'b0);
      tick();
      beat(8'h17, 32'hD000_0001, 1'b1);
      #1;
      check("t4_pending_b", m0_if.ar_ready, 1'b0);
      tick();
      r_idle();
      #1;
      check("t4_bubble_arvalid", mem_if.ar_valid, 1'b0);
      check("t4_bubble_arready", m0_if.ar_ready, 1'b0);
      tick();
      check("t4_m0_arvalid", mem_if.ar_valid, 1'b1);
      check("t4_m0_arid",    mem_if.ar_id,    8'h02);
      check("t4_m0_arready", m0_if.ar_ready,  1'b1);
      tick();
      m0_if.ar_valid  = 1'b0;
      mem_if.ar_ready = 1'b0;
      beat(8'h02, 32'hD000_0100, 1'b1);
      tick();
      r_idle();

      // 5. Reset in the middle of an M0 four-beat burst.
      issue(0, 4'h9, 32'h0000_4000, 4'd3);
      mem_if.ar_ready = 1'b1;
      tick();
      tick();
      m0_if.ar_valid  = 1'b0;
      mem_if.ar_ready = 1'b0;
      beat(8'h09, 32'h0000_0050, 1'b0);
      tick();
      beat(8'h09, 32'h0000_0051, 1'b0);
      #1;
      check("t5_beat2_rvalid", m0_if.r_valid, 1'b1);
      rst = 1'b0;
      #1;
      check("t5_rst_rvalid",  m0_if.r_valid,   1'b0);
      check("t5_rst_rdata",   m0_if.r_data,    32'h0);
      check("t5_rst_rlast",   m0_if.r_last,    1'b0);
      check("t5_rst_srready", mem_if.r_ready,  1'b0);
      check("t5_rst_arvalid", mem_if.ar_valid, 1'b0);
      clear_inputs();
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("t5_idle_arvalid", mem_if.ar_valid, 1'b0);
      ar_log.delete();
      issue(0, 4'h4, 32'h0000_4100, 4'd0);
      issue(1, 4'h4, 32'h0000_4200, 4'd0);
      tick();
      check("t5_after_rst_arvalid", mem_if.ar_valid, 1'b1);
      check("t5_after_rst_tag", mem_if.ar_id, 8'h04);
      serve(32'hE000_0000);
      serve(32'hE100_0000);

      // 6. Slave holds ARREADY low for 5 cycles in ADDR.
      got1.delete();
      issue(1, 4'hA, 32'h0000_3000, 4'd2);
      mem_if.ar_ready = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         check("t6_hold_arvalid", mem_if.ar_valid, 1'b1);
         check("t6_hold_arid",    mem_if.ar_id,    8'h1A);
         check("t6_hold_araddr",  mem_if.ar_addr,  32'h0000_3000);
         check("t6_hold_arlen",   mem_if.ar_len,   4'd2);
         check("t6_hold_arready", m1_if.ar_ready,  1'b0);
         tick();
      end
      mem_if.ar_ready = 1'b1;
      #1;
      check("t6_arready", m1_if.ar_ready, 1'b1);
      tick();
      m1_if.ar_valid  = 1'b0;
      mem_if.ar_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         beat(8'h1A, 32'hF000_0000 + 32'(i), i == 2);
         tick();
      end
      r_idle();
      check("t6_beats", got1.size(), 3);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
